// File: rtl/prod_accum_pkg.sv
// Shared types and sizing helpers for the product accumulator and its consumers.
package prod_accum_pkg;

    // Frame FSM: ACCUM gathers products, HOLD presents a finished sum.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Width needed to sum len products of two n-bit unsigned operands without wrap.
    function automatic int calc_aw(input int n, input int len);
        return 2 * n + $clog2(len);
    endfunction

endpackage

// File: rtl/prod_accum.sv
// Frame accumulator: sums LEN unsigned products per frame and presents the
// total on a registered valid/ready port, with one hold cycle per frame.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter  int N   = 9,
    parameter  int LEN = 8,
    localparam int AW  = calc_aw(N, LEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*N-1:0]  prod,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   acc_out,
    output logic            busy
);

    localparam int            CW   = $clog2(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   acc_out_q, acc_out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            accept;
    logic [AW-1:0]   prod_ext;
    logic [AW-1:0]   sum;

    // Handshake and datapath terms; prod only reaches the sum through accepted beats.
    always_comb begin
        accept   = in_valid && (state_q == ACCUM);
        prod_ext = {{(AW - 2 * N){1'b0}}, prod};
        sum      = acc_q + prod_ext;
    end

    // Next-state logic for the frame FSM and the accumulator registers.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        acc_out_d   = sum;
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d     = ACCUM;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any partial frame and any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            acc_out_q   <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs depend only on registered state, never on in_valid or out_ready.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = out_valid_q;
        acc_out   = acc_out_q;
        busy      = (cnt_q != '0) || out_valid_q;
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum with N=9, LEN=4 (AW=20).
module tb_prod_accum;

    localparam int N   = 9;
    localparam int LEN = 4;
    localparam int AW  = 20;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2*N-1:0] prod;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] acc_out;
    logic          busy;

    int n_vec;
    int n_bad;

    prod_accum #(.N(N), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for one rising edge, then return at the following falling edge.
    task automatic step(input logic v, input logic [2*N-1:0] p, input logic ordy);
        in_valid  = v;
        prod      = p;
        out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; prod = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %0b want 0", out_valid); n_bad++; end
        n_vec++; if (acc_out !== 20'd0) begin $display("FAIL rst_acc_out got %0d want 0", acc_out); n_bad++; end
        n_vec++; if (busy !== 1'b0) begin $display("FAIL rst_busy got %0b want 0", busy); n_bad++; end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready got %0b want 1", in_ready); n_bad++; end
    endtask

    task automatic test_basic();
        logic [2*N-1:0] v [4];
        v = '{18'd1, 18'd2, 18'd3, 18'd4};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, v[i], 1'b1);
            n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
                $display("FAIL basic_mid%0d got ov=%0b ir=%0b busy=%0b want 0 1 1", i, out_valid, in_ready, busy); n_bad++; end
        end
        step(1'b1, v[3], 1'b1);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd10) begin
            $display("FAIL basic_result got ov=%0b acc=%0d want 1 10", out_valid, acc_out); n_bad++; end
        n_vec++; if (in_ready !== 1'b0) begin $display("FAIL basic_hold_in_ready got %0b want 0", in_ready); n_bad++; end
        step(1'b0, '0, 1'b1);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL basic_release got ov=%0b busy=%0b ir=%0b want 0 0 1", out_valid, busy, in_ready); n_bad++; end
    endtask

    task automatic test_max();
        for (int i = 0; i < LEN; i++) step(1'b1, 18'd261121, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd1044484) begin
            $display("FAIL max_result got ov=%0b acc=%0d want 1 1044484", out_valid, acc_out); n_bad++; end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < LEN; i++) step(1'b1, 18'd5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd20 || in_ready !== 1'b0) begin
                $display("FAIL bp_hold%0d got ov=%0b acc=%0d ir=%0b want 1 20 0", i, out_valid, acc_out, in_ready); n_bad++; end
            step(1'b1, 18'd7, 1'b0);
        end
        step(1'b1, 18'd7, 1'b1);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL bp_release got ov=%0b busy=%0b want 0 0", out_valid, busy); n_bad++; end
        for (int i = 0; i < LEN; i++) step(1'b1, 18'd7, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd28) begin
            $display("FAIL bp_next_frame got ov=%0b acc=%0d want 1 28", out_valid, acc_out); n_bad++; end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_gapped();
        step(1'b1, 18'd3, 1'b1);
        step(1'b0, 18'd50, 1'b1);
        step(1'b0, 18'd50, 1'b1);
        step(1'b1, 18'd9, 1'b1);
        prod = 'x; in_valid = 1'b0; out_ready = 1'b1; @(negedge clk);
        step(1'b1, 18'd1, 1'b1);
        n_vec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL gap_mid got ov=%0b busy=%0b want 0 1", out_valid, busy); n_bad++; end
        step(1'b1, 18'd2, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd15) begin
            $display("FAIL gap_result got ov=%0b acc=%0d want 1 15", out_valid, acc_out); n_bad++; end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 18'd100, 1'b1);
        step(1'b1, 18'd200, 1'b1);
        in_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin $display("FAIL rm_busy_before got %0b want 1", busy); n_bad++; end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL rm_during_reset got busy=%0b ov=%0b want 0 0", busy, out_valid); n_bad++; end
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < LEN; i++) step(1'b1, 18'd6, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd24) begin
            $display("FAIL rm_result got ov=%0b acc=%0d want 1 24", out_valid, acc_out); n_bad++; end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < LEN; i++) step(1'b1, 18'd1, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd4 || in_ready !== 1'b0) begin
            $display("FAIL b2b_first got ov=%0b acc=%0d ir=%0b want 1 4 0", out_valid, acc_out, in_ready); n_bad++; end
        step(1'b1, 18'd2, 1'b1);
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL b2b_gap got ov=%0b ir=%0b busy=%0b want 0 1 0", out_valid, in_ready, busy); n_bad++; end
        for (int i = 0; i < LEN; i++) step(1'b1, 18'd2, 1'b1);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 20'd8) begin
            $display("FAIL b2b_second got ov=%0b acc=%0d want 1 8", out_valid, acc_out); n_bad++; end
        step(1'b0, '0, 1'b1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
